// File: rtl/tpu_pkg.sv
// Shared TPU definitions: default datapath widths, instruction opcodes and the
// input-feeder state encoding.
package tpu_pkg;

    localparam int TPU_DATA_W = 16;
    localparam int TPU_ADDR_W = 13;
    localparam int FEED_CNT_W = 8;

    typedef enum logic [2:0] {
        OP_NOP         = 3'd0,
        OP_LOAD_WEIGHT = 3'd1,
        OP_FEED_INPUT  = 3'd2,
        OP_RUN         = 3'd3,
        OP_STORE       = 3'd4
    } tpu_opcode_t;

    typedef enum logic [2:0] {
        FS_IDLE  = 3'd0,
        FS_FETCH = 3'd1,
        FS_FEED  = 3'd2,
        FS_FLUSH = 3'd3,
        FS_DONE  = 3'd4
    } feeder_state_t;

    localparam logic [FEED_CNT_W-1:0] CNT_ZERO       = 8'd0;
    localparam logic [FEED_CNT_W-1:0] CNT_ONE        = 8'd1;
    localparam logic [FEED_CNT_W-1:0] FETCH_LAST_RD  = 8'd3;
    localparam logic [FEED_CNT_W-1:0] FETCH_LAST     = 8'd4;
    localparam logic [FEED_CNT_W-1:0] FEED_LAST      = 8'd2;

    // Terminal counter value for a phase lasting n cycles (n >= 1).
    function automatic logic [FEED_CNT_W-1:0] last_cnt(input int n);
        if (n > 0) begin
            return FEED_CNT_W'(n - 1);
        end else begin
            return CNT_ZERO;
        end
    endfunction

endpackage

// File: rtl/input_skew_feeder.sv
// Loads a 2x2 input matrix from the unified buffer and feeds it diagonally
// skewed into the two left-edge systolic PEs, followed by a zero-input drain.
module input_skew_feeder
    import tpu_pkg::*;
#(
    parameter int DATA_W       = TPU_DATA_W,
    parameter int ADDR_W       = TPU_ADDR_W,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              ub_rd_en,
    output logic [ADDR_W-1:0] ub_rd_addr,
    input  logic [DATA_W-1:0] ub_rd_data,
    output logic [DATA_W-1:0] a_in1,
    output logic [DATA_W-1:0] a_in2,
    output logic              valid,
    output logic              busy,
    output logic              done
);

    localparam logic [FEED_CNT_W-1:0] FLUSH_LAST = last_cnt(FLUSH_CYCLES);

    feeder_state_t           state_r, state_nxt_s;
    logic [FEED_CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic [DATA_W-1:0]       mat_r [4];
    logic                    cap_en_s;
    logic [1:0]              cap_idx_s;
    logic                    rd_en_nxt_s, valid_nxt_s, busy_nxt_s, done_nxt_s;
    logic [ADDR_W-1:0]       rd_addr_nxt_s;
    logic [DATA_W-1:0]       a_in1_nxt_s, a_in2_nxt_s;

    // Next state plus the output values the next state will present.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = CNT_ZERO;
        rd_en_nxt_s   = 1'b0;
        rd_addr_nxt_s = ub_rd_addr;
        a_in1_nxt_s   = {DATA_W{1'b0}};
        a_in2_nxt_s   = {DATA_W{1'b0}};
        valid_nxt_s   = 1'b0;
        busy_nxt_s    = 1'b0;
        done_nxt_s    = 1'b0;
        cap_en_s      = 1'b0;
        cap_idx_s     = 2'd0;
        case (state_r)
            FS_IDLE: begin
                if (start) begin
                    state_nxt_s   = FS_FETCH;
                    rd_en_nxt_s   = 1'b1;
                    rd_addr_nxt_s = base_addr;
                    busy_nxt_s    = 1'b1;
                end else begin
                    state_nxt_s   = FS_IDLE;
                end
            end
            FS_FETCH: begin
                // Read data lags the strobe by one cycle, so word k lands at count k+1.
                busy_nxt_s = 1'b1;
                cnt_nxt_s  = cnt_r + CNT_ONE;
                cap_en_s   = (cnt_r != CNT_ZERO);
                cap_idx_s  = cnt_r[1:0] - 2'd1;
                if (cnt_r < FETCH_LAST_RD) begin
                    rd_en_nxt_s   = 1'b1;
                    rd_addr_nxt_s = ub_rd_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                end else begin
                    rd_en_nxt_s   = 1'b0;
                end
                if (cnt_r == FETCH_LAST) begin
                    state_nxt_s = FS_FEED;
                    cnt_nxt_s   = CNT_ZERO;
                    valid_nxt_s = 1'b1;
                    a_in1_nxt_s = mat_r[0];
                end else begin
                    state_nxt_s = FS_FETCH;
                end
            end
            FS_FEED: begin
                busy_nxt_s  = 1'b1;
                valid_nxt_s = 1'b1;
                cnt_nxt_s   = cnt_r + CNT_ONE;
                if (cnt_r == CNT_ZERO) begin
                    a_in1_nxt_s = mat_r[1];
                    a_in2_nxt_s = mat_r[2];
                end else if (cnt_r == CNT_ONE) begin
                    a_in2_nxt_s = mat_r[3];
                end else if (FLUSH_CYCLES > 0) begin
                    state_nxt_s = FS_FLUSH;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = FS_DONE;
                    valid_nxt_s = 1'b0;
                    busy_nxt_s  = 1'b0;
                    done_nxt_s  = 1'b1;
                end
            end
            FS_FLUSH: begin
                if (cnt_r == FLUSH_LAST) begin
                    state_nxt_s = FS_DONE;
                    done_nxt_s  = 1'b1;
                end else begin
                    valid_nxt_s = 1'b1;
                    busy_nxt_s  = 1'b1;
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            FS_DONE: begin
                state_nxt_s = FS_IDLE;
            end
            default: begin
                state_nxt_s = FS_IDLE;
            end
        endcase
    end

    // State and phase counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= FS_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ub_rd_en   <= 1'b0;
            ub_rd_addr <= {ADDR_W{1'b0}};
            a_in1      <= {DATA_W{1'b0}};
            a_in2      <= {DATA_W{1'b0}};
            valid      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            ub_rd_en   <= rd_en_nxt_s;
            ub_rd_addr <= rd_addr_nxt_s;
            a_in1      <= a_in1_nxt_s;
            a_in2      <= a_in2_nxt_s;
            valid      <= valid_nxt_s;
            busy       <= busy_nxt_s;
            done       <= done_nxt_s;
        end
    end

    // Matrix capture, row-major: a11, a12, a21, a22.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                mat_r[i] <= {DATA_W{1'b0}};
            end
        end else if (cap_en_s) begin
            mat_r[cap_idx_s] <= ub_rd_data;
        end
    end

endmodule

// File: tb/tb_input_skew_feeder.sv
// Directed bench for input_skew_feeder: default build and a zero-flush build
// side by side, checked each cycle against a cycle-offset reference model.
module tb_input_skew_feeder;

    typedef struct {
        logic        rd_en;
        logic [12:0] addr;
        logic        valid;
        logic [15:0] a1;
        logic [15:0] a2;
        logic        busy;
        logic        done;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [12:0] base_addr;
    logic [15:0] ub [0:8191];
    logic [15:0] rdd4, rdd0;

    logic        d4_rd_en, d4_valid, d4_busy, d4_done;
    logic [12:0] d4_addr;
    logic [15:0] d4_a1, d4_a2;
    logic        d0_rd_en, d0_valid, d0_busy, d0_done;
    logic [12:0] d0_addr;
    logic [15:0] d0_a1, d0_a2;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int st_cyc;
    int done_cnt4 = 0, done_cnt0 = 0, done_cyc4 = 0, done_cyc0 = 0;
    logic [31:0] q4 [$];
    logic [31:0] q0 [$];
    logic [12:0] qaddr [$];
    logic [31:0] exp_pairs [8];
    logic [12:0] exp_addrs [4];

    bit          act4 = 1'b0, act0 = 1'b0;
    int          k4 = 0, k0 = 0;
    logic [12:0] base4 = 13'd0, base0 = 13'd0;

    input_skew_feeder #(.DATA_W(16), .ADDR_W(13), .FLUSH_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .ub_rd_en(d4_rd_en), .ub_rd_addr(d4_addr), .ub_rd_data(rdd4),
        .a_in1(d4_a1), .a_in2(d4_a2), .valid(d4_valid), .busy(d4_busy), .done(d4_done)
    );

    input_skew_feeder #(.DATA_W(16), .ADDR_W(13), .FLUSH_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .ub_rd_en(d0_rd_en), .ub_rd_addr(d0_addr), .ub_rd_data(rdd0),
        .a_in1(d0_a1), .a_in2(d0_a2), .valid(d0_valid), .busy(d0_busy), .done(d0_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (d4_rd_en) rdd4 <= ub[d4_addr];
        if (d0_rd_en) rdd0 <= ub[d0_addr];
    end

    // Reference timeline: k counts edges since start acceptance (k=1 right after it).
    // Reads at k=1..4, feed at k=6..8, flush k=9..8+F, done at k=9+F.
    function automatic exp_t model_out(input bit act, input int k, input int f, input logic [12:0] base);
        exp_t e;
        logic [12:0] b1, b2, b3;
        b1 = base + 13'd1;
        b2 = base + 13'd2;
        b3 = base + 13'd3;
        e = '{1'b0, 13'd0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0};
        if (act) begin
            if (k >= 1 && k <= 4) begin
                e.rd_en = 1'b1;
                e.addr  = base + 13'(k - 1);
            end
            if (k >= 6 && k <= 8 + f) e.valid = 1'b1;
            if (k == 6) e.a1 = ub[base];
            if (k == 7) begin
                e.a1 = ub[b1];
                e.a2 = ub[b2];
            end
            if (k == 8) e.a2 = ub[b3];
            e.busy = (k <= 8 + f);
            e.done = (k == 9 + f);
        end
        return e;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            act4 <= 1'b0;
            act0 <= 1'b0;
        end else begin
            if (act4) begin
                if (k4 == 13) act4 <= 1'b0;
                else          k4 <= k4 + 1;
            end else if (start) begin
                act4 <= 1'b1; k4 <= 1; base4 <= base_addr;
            end
            if (act0) begin
                if (k0 == 9) act0 <= 1'b0;
                else         k0 <= k0 + 1;
            end else if (start) begin
                act0 <= 1'b1; k0 <= 1; base0 <= base_addr;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic cmp(input string tag, input exp_t e, input logic rd_en, input logic [12:0] addr,
                       input logic valid, input logic [15:0] a1, input logic [15:0] a2,
                       input logic busy, input logic done);
        chk({tag, ".ub_rd_en"}, 32'(rd_en), 32'(e.rd_en));
        if (e.rd_en) chk({tag, ".ub_rd_addr"}, 32'(addr), 32'(e.addr));
        chk({tag, ".valid"}, 32'(valid), 32'(e.valid));
        chk({tag, ".a_in1"}, 32'(a1), 32'(e.a1));
        chk({tag, ".a_in2"}, 32'(a2), 32'(e.a2));
        chk({tag, ".busy"}, 32'(busy), 32'(e.busy));
        chk({tag, ".done"}, 32'(done), 32'(e.done));
    endtask

    // Per-cycle compare against the model, plus trace recording for literal checks.
    always @(negedge clk) begin
        cmp("dut", model_out(act4, k4, 4, base4), d4_rd_en, d4_addr, d4_valid, d4_a1, d4_a2, d4_busy, d4_done);
        cmp("dut0", model_out(act0, k0, 0, base0), d0_rd_en, d0_addr, d0_valid, d0_a1, d0_a2, d0_busy, d0_done);
        if (d4_valid) q4.push_back({d4_a1, d4_a2});
        if (d0_valid) q0.push_back({d0_a1, d0_a2});
        if (d4_rd_en) qaddr.push_back(d4_addr);
        if (d4_done) begin done_cnt4++; done_cyc4 = cyc; end
        if (d0_done) begin done_cnt0++; done_cyc0 = cyc; end
    end

    function automatic logic [31:0] pr(input int a, input int b);
        return {a[15:0], b[15:0]};
    endfunction

    task automatic check_pairs(input string name, input bit use0, input int total, input int off, input int n);
        int sz;
        sz = use0 ? q0.size() : q4.size();
        chk({name, ".count"}, 32'(sz), 32'(total));
        for (int i = 0; i < n; i++) begin
            if (off + i < sz) chk($sformatf("%s.pair%0d", name, i),
                                  use0 ? q0[off + i] : q4[off + i], exp_pairs[i]);
        end
    endtask

    task automatic check_addrs(input string name);
        chk({name, ".count"}, 32'(qaddr.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < qaddr.size()) chk($sformatf("%s.addr%0d", name, i), 32'(qaddr[i]), 32'(exp_addrs[i]));
        end
    endtask

    task automatic check_quiet(input string name);
        chk({name, ".rd_en"}, 32'(d4_rd_en | d0_rd_en), 32'd0);
        chk({name, ".addr"}, 32'(d4_addr | d0_addr), 32'd0);
        chk({name, ".a_in"}, 32'(d4_a1 | d4_a2 | d0_a1 | d0_a2), 32'd0);
        chk({name, ".valid_busy_done"}, 32'({d4_valid, d4_busy, d4_done, d0_valid, d0_busy, d0_done}), 32'd0);
    endtask

    task automatic run_start(input logic [12:0] b);
        @(negedge clk);
        start = 1'b1;
        base_addr = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        st_cyc = cyc;
    endtask

    task automatic clear_trace();
        q4.delete(); q0.delete(); qaddr.delete();
        done_cnt4 = 0; done_cnt0 = 0;
    endtask

    initial begin
        int w, lat;
        reset = 1'b1;
        start = 1'b0;
        base_addr = 13'd0;
        for (int i = 0; i < 8192; i++) ub[i] = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        check_quiet("reset");
        @(negedge clk);
        reset = 1'b0;

        // Basic run from 0x000F
        ub[15] = 16'd11; ub[16] = 16'd12; ub[17] = 16'd21; ub[18] = 16'd22;
        clear_trace();
        run_start(13'h000F);
        repeat (16) @(posedge clk);
        #2;
        exp_pairs = '{pr(11, 0), pr(12, 21), pr(0, 22), pr(0, 0), pr(0, 0), pr(0, 0), pr(0, 0), pr(0, 0)};
        exp_addrs = '{13'h000F, 13'h0010, 13'h0011, 13'h0012};
        check_pairs("basic", 1'b0, 7, 0, 7);
        check_pairs("basic_f0", 1'b1, 3, 0, 3);
        check_addrs("basic");
        chk("basic.done_latency", 32'(done_cyc4 - st_cyc), 32'd12);
        chk("basic_f0.done_latency", 32'(done_cyc0 - st_cyc), 32'd8);
        chk("basic.done_count", 32'(done_cnt4), 32'd1);

        // Address wrap at the top of the buffer
        ub[8191] = 16'd1; ub[0] = 16'd2; ub[1] = 16'd3; ub[2] = 16'd4;
        clear_trace();
        run_start(13'h1FFF);
        repeat (16) @(posedge clk);
        #2;
        exp_pairs = '{pr(1, 0), pr(2, 3), pr(0, 4), pr(0, 0), pr(0, 0), pr(0, 0), pr(0, 0), pr(0, 0)};
        exp_addrs = '{13'h1FFF, 13'h0000, 13'h0001, 13'h0002};
        check_pairs("wrap", 1'b0, 7, 0, 3);
        check_addrs("wrap");

        // Start re-pulsed during FEED is ignored; start right after done is accepted
        clear_trace();
        run_start(13'h000F);
        repeat (6) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        base_addr = 13'h0000;
        @(posedge clk);
        #1;
        start = 1'b0;
        w = 0;
        while (!d4_done && w < 30) begin
            @(negedge clk);
            w++;
        end
        chk("repulse.done_seen", 32'(d4_done), 32'd1);
        lat = cyc - st_cyc;
        chk("repulse.done_latency", 32'(lat), 32'd12);
        run_start(13'h000F);
        repeat (16) @(posedge clk);
        #2;
        exp_pairs = '{pr(11, 0), pr(12, 21), pr(0, 22), pr(0, 0), pr(0, 0), pr(0, 0), pr(0, 0), pr(0, 0)};
        check_pairs("restart", 1'b0, 14, 7, 7);
        chk("restart.done_count", 32'(done_cnt4), 32'd2);
        chk("restart.done_latency", 32'(done_cyc4 - st_cyc), 32'd12);

        // Asynchronous reset on the second FEED cycle aborts without done
        run_start(13'h000F);
        repeat (6) @(posedge clk);
        #2;
        chk("abort.pre_valid", 32'(d4_valid), 32'd1);
        reset = 1'b1;
        #1;
        check_quiet("abort");
        clear_trace();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        chk("abort.no_done", 32'(done_cnt4 + done_cnt0), 32'd0);
        ub[32] = 16'd5; ub[33] = 16'd6; ub[34] = 16'd7; ub[35] = 16'd8;
        clear_trace();
        run_start(13'h0020);
        repeat (16) @(posedge clk);
        #2;
        exp_pairs = '{pr(5, 0), pr(6, 7), pr(0, 8), pr(0, 0), pr(0, 0), pr(0, 0), pr(0, 0), pr(0, 0)};
        check_pairs("after_reset", 1'b0, 7, 0, 3);
        check_pairs("after_reset_f0", 1'b1, 3, 0, 3);
        chk("after_reset.done_count", 32'(done_cnt4), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
